pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline stage register: the generic successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries an opaque payload and a control bundle between two pipeline stages with valid/ready flow control, a two-entry skid buffer, N-way stall, and flush-to-bubble. Instantiated once per stage boundary in the core.

---
 rtl/pipe_pkg.sv | 5 +
 rtl/pipe_stage_reg_if.sv | 9 +
 rtl/pipe_perf_cnt.sv | 13 +
 rtl/pipe_stage_reg.sv | 72 +++++++
 tb/tb_pipe_stage_reg.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the handshaked pipeline stage register
package pipe_pkg;
    typedef enum logic [1:0] {OCC_EMPTY = 2'd0, OCC_ONE = 2'd1, OCC_TWO = 2'd2} pipe_occ_t;
    localparam int PERF_CNT_W = 32;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready stream carrying a payload and control bundle
interface pipe_stage_reg_if #(parameter int DATA_W = 128, parameter int CTRL_W = 16) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    modport master (output valid, data, ctrl, input ready);
    modport slave  (input valid, data, ctrl, output ready);
endinterface

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: saturating event counter, cleared only by reset
module pipe_perf_cnt
    import pipe_pkg::*;
#(parameter int W = PERF_CNT_W) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (en && !(&count)) count <= count + W'(1);
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid pipeline register with N-way stall and flush-to-bubble.
// Define PIPE_STAGE_REG_PERF_EN to build the stall/flush performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int CTRL_W     = 16,
    parameter int STALL_SRCS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipe_stage_reg_if.slave       up,
    pipe_stage_reg_if.master      dn,
    input  logic [STALL_SRCS-1:0] stall,
    input  logic                  flush,
    output logic [1:0]            occupancy,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_count
);
    pipe_occ_t         state, state_nxt;
    logic [DATA_W-1:0] main_data, main_data_nxt, skid_data, skid_data_nxt;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt, skid_ctrl, skid_ctrl_nxt;
    logic              stall_any, accept, drain, load_in_main, load_skid_main, load_skid;

    assign stall_any = |stall;
    assign up.ready  = (state != OCC_TWO) && !stall_any;
    assign dn.valid  = (state != OCC_EMPTY);
    assign dn.data   = main_data;
    assign dn.ctrl   = main_ctrl;
    assign occupancy = 2'(state);
    assign accept    = up.valid && up.ready;
    assign drain     = dn.valid && dn.ready && !stall_any;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= OCC_EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state     <= state_nxt;
            main_data <= main_data_nxt;
            main_ctrl <= main_ctrl_nxt;
            skid_data <= skid_data_nxt;
            skid_ctrl <= skid_ctrl_nxt;
        end

    // Flush wins over everything: the stage empties and the incoming beat is dropped.
    always_comb begin
        load_in_main   = accept && (state == OCC_EMPTY || drain);
        load_skid_main = drain && state == OCC_TWO;
        load_skid      = accept && !drain && state == OCC_ONE;
        state_nxt      = flush ? OCC_EMPTY
                       : load_skid ? OCC_TWO
                       : (drain && !accept) ? (state == OCC_TWO ? OCC_ONE : OCC_EMPTY)
                       : (accept && state == OCC_EMPTY) ? OCC_ONE
                       : state;
        main_data_nxt  = flush ? '0 : load_in_main ? up.data : load_skid_main ? skid_data : main_data;
        main_ctrl_nxt  = flush ? '0 : load_in_main ? up.ctrl : load_skid_main ? skid_ctrl : main_ctrl;
        skid_data_nxt  = flush ? '0 : load_skid ? up.data : skid_data;
        skid_ctrl_nxt  = flush ? '0 : load_skid ? up.ctrl : skid_ctrl;
    end

`ifdef PIPE_STAGE_REG_PERF_EN
    pipe_perf_cnt #(.W(PERF_CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .en(stall_any), .count(stall_cycles));
    pipe_perf_cnt #(.W(PERF_CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .en(flush), .count(flush_count));
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;
    import pipe_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  stall = '0;
    logic        flush = 1'b0;
    logic [1:0]  occupancy;
    logic [31:0] stall_cycles, flush_count;
    int          n_pass = 0, n_total = 0;

    pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(16)) up ();
    pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(16)) dn ();

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(16), .STALL_SRCS(2)) dut (
        .clk(clk), .rst_n(rst_n), .up(up), .dn(dn), .stall(stall), .flush(flush),
        .occupancy(occupancy), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

`ifdef PIPE_STAGE_REG_PERF_EN
    localparam logic [31:0] EXP_STALLS = 32'd3;
    localparam logic [31:0] EXP_FLUSHES = 32'd1;
`else
    localparam logic [31:0] EXP_STALLS = 32'd0;
    localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [127:0] d, input logic [15:0] c);
        up.valid = 1'b1;
        up.data  = d;
        up.ctrl  = c;
        tick();
    endtask

    initial begin
        up.valid = 1'b0;
        up.data  = '0;
        up.ctrl  = '0;
        dn.ready = 1'b0;
        #12;
        check("rst_out_valid", 128'(dn.valid), 128'd0);
        check("rst_out_data", dn.data, 128'd0);
        check("rst_out_ctrl", 128'(dn.ctrl), 128'd0);
        check("rst_occ", 128'(occupancy), 128'd0);
        check("rst_in_ready", 128'(up.ready), 128'd1);
        check("rst_stall_cnt", 128'(stall_cycles), 128'd0);
        check("rst_flush_cnt", 128'(flush_count), 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single beat latency
        dn.ready = 1'b1;
        push(128'h1234, 16'h5);
        up.valid = 1'b0;
        check("lat_valid", 128'(dn.valid), 128'd1);
        check("lat_data", dn.data, 128'h1234);
        check("lat_ctrl", 128'(dn.ctrl), 128'h5);
        check("lat_occ", 128'(occupancy), 128'd1);
        tick();
        check("lat_drained", 128'(occupancy), 128'd0);

        // sustained throughput
        for (int i = 1; i <= 8; i++) begin
            push(128'(i), 16'(i));
            check("stream_data", dn.data, 128'(i));
            check("stream_in_ready", 128'(up.ready), 128'd1);
        end
        up.valid = 1'b0;
        tick();
        check("stream_empty", 128'(dn.valid), 128'd0);

        // skid fill and ordered drain
        dn.ready = 1'b0;
        push(128'hA, 16'h0);
        push(128'hB, 16'h0);
        up.valid = 1'b0;
        check("skid_occ2", 128'(occupancy), 128'd2);
        check("skid_in_ready", 128'(up.ready), 128'd0);
        check("skid_hold_a", dn.data, 128'hA);
        tick();
        check("skid_still_a", dn.data, 128'hA);
        dn.ready = 1'b1;
        tick();
        check("skid_then_b", dn.data, 128'hB);
        check("skid_ready_back", 128'(up.ready), 128'd1);
        check("skid_occ1", 128'(occupancy), 128'd1);
        tick();
        check("skid_empty", 128'(dn.valid), 128'd0);

        // stall freezes the stage
        push(128'h11, 16'h1);
        stall = 2'b10;
        up.data = 128'h22;
        #1;
        check("stall_in_ready", 128'(up.ready), 128'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_data", dn.data, 128'h11);
            check("stall_occ", 128'(occupancy), 128'd1);
        end
        check("stall_count", 128'(stall_cycles), 128'(EXP_STALLS));
        stall = 2'b00;
        tick();
        check("stall_next", dn.data, 128'h22);
        check("stall_next_occ", 128'(occupancy), 128'd1);
        up.valid = 1'b0;
        tick();
        check("stall_empty", 128'(occupancy), 128'd0);

        // flush beats stall and incoming beat
        dn.ready = 1'b0;
        push(128'h31, 16'h1);
        push(128'h32, 16'h2);
        check("flush_pre_occ", 128'(occupancy), 128'd2);
        up.data = 128'h33;
        up.ctrl = 16'h3;
        stall = 2'b01;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall = 2'b00;
        up.valid = 1'b0;
        check("flush_valid", 128'(dn.valid), 128'd0);
        check("flush_ctrl", 128'(dn.ctrl), 128'd0);
        check("flush_data", dn.data, 128'd0);
        check("flush_occ", 128'(occupancy), 128'd0);
        check("flush_count", 128'(flush_count), 128'(EXP_FLUSHES));
        dn.ready = 1'b1;
        tick();
        check("flush_no_beat", 128'(dn.valid), 128'd0);

        // asynchronous reset mid-stream
        dn.ready = 1'b0;
        push(128'h44, 16'h4);
        up.valid = 1'b0;
        check("arst_pre_valid", 128'(dn.valid), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 128'(dn.valid), 128'd0);
        check("arst_data", dn.data, 128'd0);
        check("arst_occ", 128'(occupancy), 128'd0);
        check("arst_flush_cnt", 128'(flush_count), 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
